// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_pkg
// Purpose  : Shared types and constants for the LC-3 fetch pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package lc3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_ERR   = 3'd5
    } fetch_state_t;

    localparam logic [1:0] PCSEL_INC = 2'd0;
    localparam logic [1:0] PCSEL_EAB = 2'd1;
    localparam logic [1:0] PCSEL_BUS = 2'd2;

    // Redirect selects other than "bus" (including the reserved codes) fall back to EAB.
    function automatic logic [1:0] redirect_target(input logic [1:0] sel);
        return (sel == PCSEL_BUS) ? PCSEL_BUS : PCSEL_EAB;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : lc3_wait_timer
// Purpose  : Memory wait counter with clear, enable and terminal-count flag.
//            tc is high during the TIMEOUT-th enabled cycle after a clear.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int              CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_max  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles, saturating at TIMEOUT so the flag can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != c_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tc = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/lc3_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : lc3_ifetch
// Purpose  : LC-3 instruction-fetch sequencer. Reads memory at the PC, steps
//            the PC, hands the word to decode via valid/ready, and applies
//            redirects while draining any read already in flight.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_ifetch
    import lc3_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              ldPC,
    output logic [1:0]        selPC,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [1:0]        redirect_sel,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              fetch_err
);

    fetch_state_t      r_state;
    fetch_state_t      w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ir_pc;
    logic              r_err;
    logic              w_tc;
    logic              w_timer_clr;
    logic              w_timer_en;

    assign w_timer_clr = (r_state == ST_ADDR);
    assign w_timer_en  = (r_state == ST_WAIT) || (r_state == ST_FLUSH);

    lc3_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (w_timer_clr),
        .en  (w_timer_en),
        .tc  (w_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a redirect abandons whatever the current read would have produced.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run) w_next = ST_ADDR;
            end
            ST_ADDR: begin
                w_next = redirect ? ST_FLUSH : ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    if (redirect) w_next = run ? ST_ADDR : ST_IDLE;
                    else          w_next = ST_HOLD;
                end else if (w_tc) begin
                    w_next = ST_ERR;
                end else if (redirect) begin
                    w_next = ST_FLUSH;
                end
            end
            ST_HOLD: begin
                if (redirect || ir_ready) w_next = run ? ST_ADDR : ST_IDLE;
            end
            ST_FLUSH: begin
                if (mem_ready)  w_next = run ? ST_ADDR : ST_IDLE;
                else if (w_tc)  w_next = ST_ERR;
            end
            ST_ERR: begin
                w_next = ST_ERR;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: strobes follow the state, redirect overrides the PC select.
    always_comb begin
        ldPC     = 1'b0;
        selPC    = PCSEL_INC;
        mem_rd   = 1'b0;
        mem_addr = '0;
        ir_valid = 1'b0;
        if (redirect && (r_state != ST_ERR)) begin
            ldPC  = 1'b1;
            selPC = redirect_target(redirect_sel);
        end
        case (r_state)
            ST_ADDR: begin
                ldPC     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = pc_in;
            end
            ST_WAIT, ST_FLUSH: begin
                mem_rd   = 1'b1;
                mem_addr = r_addr;
            end
            ST_HOLD: begin
                ir_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Fetch address, instruction register and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_ir    <= '0;
            r_ir_pc <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == ST_ADDR) r_addr <= pc_in;
            if ((r_state == ST_WAIT) && mem_ready && !redirect) begin
                r_ir    <= mem_rdata;
                r_ir_pc <= r_addr;
            end
            if (w_next == ST_ERR) r_err <= 1'b1;
        end
    end

    assign ir_out    = r_ir;
    assign ir_pc     = r_ir_pc;
    assign fetch_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lc3_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_ifetch
// Purpose  : Directed self-checking bench for lc3_ifetch with a PC/memory
//            model and an instruction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [15:0] pc_in = 16'h3000;
    logic        ldPC;
    logic [1:0]  selPC;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic        redirect = 1'b0;
    logic [1:0]  redirect_sel = 2'd0;
    logic [15:0] ir_out;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        fetch_err;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 0;
    int          wcnt = 0;
    int          n_inc = 0;
    int          n0;
    logic [15:0] eab_val = 16'h0;
    logic [15:0] bus_val = 16'h0;
    logic [15:0] dead_addr = 16'hFFFF;
    logic [15:0] req_addr = 16'h0;
    logic        cap_ld = 1'b0;
    logic [1:0]  cap_sel = 2'd0;
    logic        cap_rd = 1'b0;
    logic        cap_ready = 1'b0;
    logic [31:0] sb[$];
    logic [31:0] exp_word;

    lc3_ifetch #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .pc_in        (pc_in),
        .ldPC         (ldPC),
        .selPC        (selPC),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .redirect     (redirect),
        .redirect_sel (redirect_sel),
        .ir_out       (ir_out),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == dead_addr) return 16'hDEAD;
        if (a == 16'h3000)  return 16'h1234;
        if (a == 16'h3001)  return 16'h5678;
        return a ^ 16'hA5A5;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge (stimulus point).
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) cyc();
        check("drain_queue", sb.size(), 0);
    endtask

    // PC stage, memory responder and scoreboard monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst)           wcnt = 0;
            else if (cap_rd)    wcnt = cap_ready ? 0 : wcnt + 1;
            else                wcnt = 0;
            if (rst && cap_ld) begin
                case (cap_sel)
                    2'd0:    pc_in = pc_in + 16'd1;
                    2'd1:    pc_in = eab_val;
                    default: pc_in = bus_val;
                endcase
            end
            #2;
            if (mem_rd && wcnt == 0) req_addr = mem_addr;
            mem_ready = mem_rd && (mem_lat >= 0) && (wcnt == mem_lat + 1);
            mem_rdata = mem_word(req_addr);
            #6;
            cap_ld    = ldPC;
            cap_sel   = selPC;
            cap_rd    = mem_rd;
            cap_ready = mem_ready;
            if (rst && ldPC && selPC == 2'd0) n_inc++;
            if (rst && ir_valid && ir_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected observed=%0h expected=none", {ir_out, ir_pc});
                end
                if (sb.size() != 0) begin
                    exp_word = sb.pop_front();
                    check("sb_ir", {ir_out, ir_pc}, exp_word);
                end
            end
        end
    end

    initial begin
        // Reset state
        cyc();
        cyc();
        @(negedge clk);
        check("rst_ldpc", ldPC, 0);
        check("rst_memrd", mem_rd, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", ir_valid, 0);
        check("rst_ir", {ir_out, ir_pc}, 0);
        check("rst_err", fetch_err, 0);

        // Linear fetch with zero-wait memory
        cyc();
        rst = 1'b1; run = 1'b1; ir_ready = 1'b1;
        n0 = n_inc;
        sb.push_back({16'h1234, 16'h3000});
        sb.push_back({16'h5678, 16'h3001});
        @(negedge clk);
        check("lin_idle_rd", mem_rd, 0);
        cyc(); @(negedge clk);
        check("lin_addr0", {ldPC, selPC, mem_rd, mem_addr}, {1'b1, 2'd0, 1'b1, 16'h3000});
        cyc(); @(negedge clk);
        check("lin_wait0", {ldPC, mem_rd, mem_addr}, {1'b0, 1'b1, 16'h3000});
        cyc(); @(negedge clk);
        check("lin_hold0", {ir_valid, ir_out, ir_pc}, {1'b1, 16'h1234, 16'h3000});
        cyc();
        run = 1'b0;
        @(negedge clk);
        check("lin_addr1", {ldPC, selPC, mem_rd, mem_addr}, {1'b1, 2'd0, 1'b1, 16'h3001});
        drain(20);
        check("lin_inc_count", n_inc - n0, 2);

        // Wait states and backpressure
        cyc();
        pc_in = 16'h3000; mem_lat = 3; run = 1'b1; ir_ready = 1'b0;
        n0 = n_inc;
        sb.push_back({16'h1234, 16'h3000});
        cyc();
        run = 1'b0;
        @(negedge clk);
        check("ws_addr", {ldPC, mem_addr}, {1'b1, 16'h3000});
        for (int i = 0; i < 4; i++) begin
            cyc(); @(negedge clk);
            check("ws_wait_addr", {mem_rd, ldPC, mem_addr}, {1'b1, 1'b0, 16'h3000});
        end
        for (int i = 0; i < 5; i++) begin
            cyc(); @(negedge clk);
            check("bp_hold", {ir_valid, mem_rd, ir_out}, {1'b1, 1'b0, 16'h1234});
        end
        cyc();
        ir_ready = 1'b1;
        drain(10);
        check("ws_inc_count", n_inc - n0, 1);

        // Redirect during WAIT
        cyc();
        mem_lat = 2; eab_val = 16'h4000; dead_addr = 16'h3001; run = 1'b1; ir_ready = 1'b1;
        sb.push_back({16'hE5A5, 16'h4000});
        cyc();
        cyc();
        redirect = 1'b1; redirect_sel = 2'd1;
        @(negedge clk);
        check("rd_redirect_strobe", {ldPC, selPC}, {1'b1, 2'd1});
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        check("rd_flush", {mem_rd, ir_valid, mem_addr}, {1'b1, 1'b0, 16'h3001});
        cyc();
        cyc();
        run = 1'b0;
        @(negedge clk);
        check("rd_new_addr", {ldPC, selPC, mem_addr}, {1'b1, 2'd0, 16'h4000});
        drain(20);

        // Data returned in the same cycle as the timeout is still accepted
        cyc();
        pc_in = 16'h5000; mem_lat = 7; run = 1'b1;
        sb.push_back({16'hF5A5, 16'h5000});
        cyc();
        run = 1'b0;
        drain(40);
        check("edge_no_err", fetch_err, 0);

        // Timeout to ERR
        cyc();
        mem_lat = -1; run = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) cyc();
        cyc(); @(negedge clk);
        check("to_wait8", {fetch_err, mem_rd}, {1'b0, 1'b1});
        cyc(); @(negedge clk);
        check("to_err", {fetch_err, mem_rd, ldPC, ir_valid}, {1'b1, 1'b0, 1'b0, 1'b0});
        cyc();
        redirect = 1'b1; redirect_sel = 2'd2;
        @(negedge clk);
        check("to_err_redirect", {fetch_err, ldPC, mem_rd}, {1'b1, 1'b0, 1'b0});
        cyc();
        redirect = 1'b0; rst = 1'b0; run = 1'b0;
        #1;
        check("to_err_reset", fetch_err, 0);

        // Asynchronous reset in the middle of WAIT
        cyc();
        rst = 1'b1; run = 1'b1;
        cyc();
        cyc(); @(negedge clk);
        check("ar_wait_rd", mem_rd, 1);
        cyc();
        rst = 1'b0;
        #1;
        check("ar_outputs", {ldPC, selPC, mem_rd, mem_addr, ir_valid, fetch_err},
              {1'b0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b0});
        check("ar_ir", {ir_out, ir_pc}, 0);
        cyc();
        check("final_queue", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
